cycle_accumulator: RTL

Sits directly downstream of `cycle_counter` and accumulates a signed sample stream point-by-point over a programmable number of counter cycles. Each sample is summed into the accumulator entry addressed by the counter's `fast_count`. When the run completes, the per-point sums are exposed on a registered read port for the host or a downstream averager. Typical use is coherent averaging of periodic ADC waveforms synchronised to the counter.

---
 rtl/cycle_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cycle_accumulator.sv
// Point-by-point coherent accumulator fed by cycle_counter; sums din into mem[fast_count] over n_avg cycles.
// Optional build macro CYCLE_ACCUMULATOR_AVG_SHIFT_EN adds an arithmetic right shift on the read port.
module cycle_accumulator #(
    parameter int unsigned FAST_COUNT_WIDTH = 5,
    parameter int unsigned SLOW_COUNT_WIDTH = 10,
    parameter int unsigned DATA_WIDTH       = 14,
    parameter int unsigned ACC_WIDTH        = DATA_WIDTH + SLOW_COUNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               clken,
    input  logic        [FAST_COUNT_WIDTH-1:0] fast_count,
    input  logic                               end_cycle,
    input  logic        [DATA_WIDTH-1:0]       din,
    input  logic                               start,
    input  logic        [SLOW_COUNT_WIDTH-1:0] n_avg,
    output logic                               busy,
    output logic                               ready,
`ifdef CYCLE_ACCUMULATOR_AVG_SHIFT_EN
    input  logic        [4:0]                  avg_shift,
`endif
    input  logic        [FAST_COUNT_WIDTH-1:0] rd_addr,
    output logic signed [ACC_WIDTH-1:0]        rd_data
);

    localparam int unsigned DEPTH = 2 ** FAST_COUNT_WIDTH;
    localparam int unsigned EXT_W = ACC_WIDTH - DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    logic [SLOW_COUNT_WIDTH-1:0] r_cyc;
    logic [SLOW_COUNT_WIDTH-1:0] r_n_reg;
    logic [ACC_WIDTH-1:0]        r_mem [DEPTH];

    logic [SLOW_COUNT_WIDTH-1:0] w_n_eff;
    logic                        w_last_cycle;
    logic                        w_wr_en;
    logic [ACC_WIDTH-1:0]        w_din_ext;
    logic [ACC_WIDTH-1:0]        w_base;
    logic [ACC_WIDTH-1:0]        w_wr_sum;
    logic signed [ACC_WIDTH-1:0] w_rd_val;

`ifdef CYCLE_ACCUMULATOR_AVG_SHIFT_EN
    logic [4:0]                  r_avg_shift;
`endif

    // A zero run length is promoted to one cycle.
    always_comb begin
        w_n_eff      = (n_avg == '0) ? SLOW_COUNT_WIDTH'(1) : n_avg;
        w_last_cycle = (r_cyc == (r_n_reg - SLOW_COUNT_WIDTH'(1)));
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_n_reg <= SLOW_COUNT_WIDTH'(1);
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= SYNC;
                        r_n_reg <= w_n_eff;
                        r_cyc   <= '0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                SYNC: begin
                    if (clken && end_cycle) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (clken && end_cycle) begin
                        if (w_last_cycle) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            r_cyc <= r_cyc + SLOW_COUNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_ACCUMULATOR_AVG_SHIFT_EN
    // Shift amount is frozen for the whole run, like n_avg.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_avg_shift <= '0;
        end else if (start && (r_state == IDLE || r_state == DONE)) begin
            r_avg_shift <= avg_shift;
        end
    end
`endif

    // Single-cycle read-modify-write; cycle 0 discards stale contents.
    always_comb begin
        w_wr_en   = (r_state == ACCUM) && clken;
        w_din_ext = {{EXT_W{din[DATA_WIDTH-1]}}, din};
        w_base    = (r_cyc == '0) ? '0 : r_mem[fast_count];
        w_wr_sum  = w_base + w_din_ext;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[fast_count] <= w_wr_sum;
        end
    end

    // Read port runs every clock regardless of state.
    always_comb begin
`ifdef CYCLE_ACCUMULATOR_AVG_SHIFT_EN
        w_rd_val = $signed(r_mem[rd_addr]) >>> r_avg_shift;
`else
        w_rd_val = $signed(r_mem[rd_addr]);
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_val;
        end
    end

endmodule
